// File: rtl/uart_pkg.sv
// uart_pkg: register map, bit positions and FSM state
// type shared by the mmio_uart block.
package uart_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_DIV_LO = 3'd4;
  localparam logic [2:0] REG_DIV_HI = 3'd5;

  localparam int ST_RX_AVAIL  = 0;
  localparam int ST_RX_FULL   = 1;
  localparam int ST_TX_EMPTY  = 2;
  localparam int ST_TX_FULL   = 3;
  localparam int ST_OVERRUN   = 4;
  localparam int ST_FRAME_ERR = 5;

  localparam int CTRL_CLR   = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_LB    = 2;

  localparam int DIV_MIN = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/mmio_uart_if.sv
// mmio_uart_if: MMIO access port between the data-memory
// controller (master) and the UART (slave).
interface mmio_uart_if;

  logic       tx_wen;
  logic       rx_ren;
  logic [2:0] uart_addr;
  logic [7:0] uart_din;
  logic [7:0] uart_dout;

  modport master (
    output tx_wen, rx_ren, uart_addr, uart_din,
    input  uart_dout
  );

  modport slave (
    input  tx_wen, rx_ren, uart_addr, uart_din,
    output uart_dout
  );

endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: 8-bit synchronous FIFO with flush and a
// combinational head; push at full succeeds with a pop.
module uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_push}
                 - {{AW{1'b0}}, do_pop};
    end
  end

  // storage array, contents only meaningful below cnt
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart.sv
// mmio_uart: MMIO UART with TX/RX FIFOs, baud divisor and
// 8N1 FSMs. Optional loopback: UART_LOOPBACK_EN.
module mmio_uart
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_DEFAULT = 868,
  parameter int DIV_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  mmio_uart_if.slave bus,
  input  logic       rxd,
  output logic       txd,
  output logic       rx_irq
);

  typedef logic [DIV_W-1:0] div_t;

  div_t div_q, eff_div, reload, half;
  logic wr_en, tx_push, ctrl_wr, flush, clr, rx_pop;
  logic tx_full, tx_empty, tx_pop;
  logic rx_full, rx_empty, rx_push;
  logic [7:0] tx_dout, rx_dout;
  logic overrun, frame_err, ovr_set, ferr_set, lb;
  logic rx_in, rx_s;
  logic [1:0] sync_q;

  uart_state_e tx_st_q, tx_st_d;
  div_t        tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_tc;

  uart_state_e rx_st_q, rx_st_d;
  div_t        rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_wait_q, rx_wait_d;
  logic        rx_tc;

  assign wr_en   = bus.tx_wen && !bus.rx_ren;
  assign tx_push = wr_en && (bus.uart_addr == REG_DATA);
  assign ctrl_wr = wr_en && (bus.uart_addr == REG_CTRL);
  assign flush   = ctrl_wr && bus.uart_din[CTRL_FLUSH];
  assign clr     = ctrl_wr && bus.uart_din[CTRL_CLR];
  assign rx_pop  = bus.rx_ren && !rx_empty
                && (bus.uart_addr == REG_DATA);

  assign eff_div = (div_q < div_t'(DIV_MIN))
                 ? div_t'(DIV_MIN) : div_q;
  assign reload  = eff_div - div_t'(1);
  assign half    = (eff_div >> 1) - div_t'(1);
  assign rx_irq  = !rx_empty;
  assign tx_tc   = (tx_cnt_q == '0);
  assign rx_tc   = (rx_cnt_q == '0);

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(tx_push), .pop(tx_pop), .flush(flush),
    .din(bus.uart_din), .dout(tx_dout),
    .full(tx_full), .empty(tx_empty)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(rx_push), .pop(rx_pop), .flush(flush),
    .din(rx_sh_q), .dout(rx_dout),
    .full(rx_full), .empty(rx_empty)
  );

`ifdef UART_LOOPBACK_EN
  logic lb_q;
  // loopback enable bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       lb_q <= 1'b0;
    else if (ctrl_wr) lb_q <= bus.uart_din[CTRL_LB];
  end
  assign lb = lb_q;
`else
  assign lb = 1'b0;
`endif

  assign rx_in = lb ? txd : rxd;
  assign rx_s  = sync_q[1];

  // divisor and sticky error flags; a set beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= div_t'(DIV_DEFAULT);
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr_en && bus.uart_addr == REG_DIV_LO)
        div_q[7:0] <= bus.uart_din;
      if (wr_en && bus.uart_addr == REG_DIV_HI)
        div_q[15:8] <= bus.uart_din;
      if (clr) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (ovr_set)  overrun   <= 1'b1;
      if (ferr_set) frame_err <= 1'b1;
    end
  end

  // combinational register read mux
  always_comb begin
    bus.uart_dout = 8'h00;
    unique case (bus.uart_addr)
      REG_DATA:   bus.uart_dout = rx_empty ? 8'h00 : rx_dout;
      REG_STATUS: begin
        bus.uart_dout[ST_RX_AVAIL]  = !rx_empty;
        bus.uart_dout[ST_RX_FULL]   = rx_full;
        bus.uart_dout[ST_TX_EMPTY]  = tx_empty;
        bus.uart_dout[ST_TX_FULL]   = tx_full;
        bus.uart_dout[ST_OVERRUN]   = overrun;
        bus.uart_dout[ST_FRAME_ERR] = frame_err;
      end
      REG_CTRL:   bus.uart_dout[CTRL_LB] = lb;
      REG_DIV_LO: bus.uart_dout = div_q[7:0];
      REG_DIV_HI: bus.uart_dout = div_q[15:8];
      default:    bus.uart_dout = 8'h00;
    endcase
  end

  // txd is idle high, so reset drives it high at once
  assign txd = (tx_st_q == START) ? 1'b0
             : (tx_st_q == DATA)  ? tx_sh_q[0] : 1'b1;

  // TX and RX FSM registers plus input synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q   <= IDLE;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      rx_st_q   <= IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_wait_q <= 1'b0;
      sync_q    <= 2'b11;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_wait_q <= rx_wait_d;
      sync_q    <= {sync_q[0], rx_in};
    end
  end

  // TX next state: each state holds for eff_div clocks
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_pop   = 1'b0;
    if (!tx_tc) tx_cnt_d = tx_cnt_q - div_t'(1);
    unique case (tx_st_q)
      IDLE: if (!tx_empty) begin
        tx_pop   = 1'b1;
        tx_sh_d  = tx_dout;
        tx_cnt_d = reload;
        tx_st_d  = START;
      end
      START: if (tx_tc) begin
        tx_cnt_d = reload;
        tx_bit_d = '0;
        tx_st_d  = DATA;
      end
      DATA: if (tx_tc) begin
        tx_cnt_d = reload;
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        if (tx_bit_q == 3'd7) tx_st_d = STOP;
        else tx_bit_d = tx_bit_q + 3'd1;
      end
      STOP: if (tx_tc) begin
        if (!tx_empty) begin
          tx_pop   = 1'b1;
          tx_sh_d  = tx_dout;
          tx_cnt_d = reload;
          tx_st_d  = START;
        end else begin
          tx_st_d = IDLE;
        end
      end
    endcase
  end

  // RX next state: mid-bit sampling, stop check, errors
  always_comb begin
    rx_st_d   = rx_st_q;
    rx_cnt_d  = rx_cnt_q;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_wait_d = rx_wait_q;
    rx_push   = 1'b0;
    ovr_set   = 1'b0;
    ferr_set  = 1'b0;
    if (!rx_tc) rx_cnt_d = rx_cnt_q - div_t'(1);
    unique case (rx_st_q)
      IDLE: if (!rx_s) begin
        rx_cnt_d = half;
        rx_st_d  = START;
      end
      START: if (rx_tc) begin
        if (rx_s) begin
          rx_st_d = IDLE;
        end else begin
          rx_cnt_d = reload;
          rx_bit_d = '0;
          rx_st_d  = DATA;
        end
      end
      DATA: if (rx_tc) begin
        rx_sh_d  = {rx_s, rx_sh_q[7:1]};
        rx_cnt_d = reload;
        if (rx_bit_q == 3'd7) rx_st_d = STOP;
        else rx_bit_d = rx_bit_q + 3'd1;
      end
      STOP: begin
        if (rx_wait_q) begin
          if (rx_s) begin
            rx_wait_d = 1'b0;
            rx_st_d   = IDLE;
          end
        end else if (rx_tc) begin
          if (rx_s) begin
            if (rx_full && !rx_pop) ovr_set = 1'b1;
            else rx_push = 1'b1;
            rx_st_d = IDLE;
          end else begin
            ferr_set  = 1'b1;
            rx_wait_d = 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mmio_uart.sv
// tb_mmio_uart: directed + random checks of mmio_uart
// against a serial-frame and queue reference model.
module tb_mmio_uart;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;
  logic txd;
  logic rx_irq;

  mmio_uart_if bus();

  mmio_uart dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .rxd(rxd),
    .txd(txd),
    .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] txq[$];
  logic [7:0] rxm[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a,
                    input logic [7:0] d);
    @(negedge clk);
    bus.tx_wen = 1'b1;
    bus.uart_addr = a;
    bus.uart_din = d;
    @(negedge clk);
    bus.tx_wen = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a,
                    output logic [7:0] d);
    @(negedge clk);
    bus.rx_ren = 1'b1;
    bus.uart_addr = a;
    #1 d = bus.uart_dout;
    @(negedge clk);
    bus.rx_ren = 1'b0;
  endtask

  task automatic rchk(input string tag,
                      input logic [2:0] a,
                      input logic [7:0] e);
    logic [7:0] d;
    rd(a, d);
    chk(tag, 32'(d), 32'(e));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_div(input logic [15:0] d);
    wr(3'd4, d[7:0]);
    wr(3'd5, d[15:8]);
  endtask

  // drive one 8N1 frame on rxd, div clocks per bit
  task automatic send(input logic [7:0] b,
                      input logic stp,
                      input int div);
    logic [9:0] fr;
    fr = {stp, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (div) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  // decode nfr contiguous frames from txd, mid-bit sampled
  task automatic txmon(input int nfr, input int div);
    logic [9:0] fr;
    logic [7:0] e;
    int found;
    found = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (txd == 1'b0) begin
        found = 1;
        break;
      end
    end
    chk("tx_start_seen", 32'(found), 32'd1);
    for (int f = 0; f < nfr; f++) begin
      for (int k = 0; k < 10; k++) begin
        repeat ((f == 0 && k == 0) ? div / 2 : div)
          @(negedge clk);
        fr[k] = txd;
      end
      e = txq.pop_front();
      chk("tx_start_bit", 32'(fr[0]), 32'd0);
      chk("tx_byte", 32'(fr[8:1]), 32'(e));
      chk("tx_stop_bit", 32'(fr[9]), 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] q[18];
    logic ovr;
    int low;
    logic [7:0] st;

    bus.tx_wen = 1'b0;
    bus.rx_ren = 1'b0;
    bus.uart_addr = 3'd0;
    bus.uart_din = 8'h00;

    idle(3);
    chk("rst_txd_in_reset", 32'(txd), 32'd1);
    rst_n = 1'b1;
    idle(1);
    chk("rst_dout", 32'(bus.uart_dout), 32'h0);
    chk("rst_irq", 32'(rx_irq), 32'd0);
    chk("rst_txd", 32'(txd), 32'd1);
    rchk("rst_status", 3'd1, 8'h04);
    rchk("rst_div_lo", 3'd4, 8'h64);
    rchk("rst_div_hi", 3'd5, 8'h03);
    rchk("rst_ctrl", 3'd2, 8'h00);
    rchk("addr3", 3'd3, 8'h00);
    rchk("addr7", 3'd7, 8'h00);
    rchk("rx_empty_read", 3'd0, 8'h00);

    // single TX frame at divisor 4
    set_div(16'd4);
    rchk("div_lo_wr", 3'd4, 8'h04);
    b = 8'hA5;
    txq.push_back(b);
    fork
      wr(3'd0, b);
      txmon(1, 4);
    join
    idle(2);
    rchk("tx_empty_after", 3'd1, 8'h04);

    // divisor below minimum behaves as 4
    set_div(16'd2);
    rchk("div_lo_raw", 3'd4, 8'h02);
    b = 8'($urandom);
    txq.push_back(b);
    fork
      wr(3'd0, b);
      txmon(1, 4);
    join

    // 17 back-to-back writes, an 18th dropped at full
    set_div(16'd4);
    for (int i = 0; i < 18; i++) q[i] = 8'($urandom);
    for (int i = 0; i < 17; i++) txq.push_back(q[i]);
    fork
      begin
        for (int i = 0; i < 17; i++) wr(3'd0, q[i]);
        rchk("tx_full", 3'd1, 8'h08);
        wr(3'd0, q[17]);
      end
      txmon(17, 4);
    join
    low = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd == 1'b0) low = 1;
    end
    chk("tx_drop_at_full", 32'(low), 32'd0);
    rchk("tx_drained", 3'd1, 8'h04);

    // RX single frame at divisor 8
    set_div(16'd8);
    send(8'h3C, 1'b1, 8);
    idle(4);
    chk("rx_irq_set", 32'(rx_irq), 32'd1);
    rchk("rx_3c", 3'd0, 8'h3C);
    rchk("rx_empty_again", 3'd0, 8'h00);
    chk("rx_irq_clr", 32'(rx_irq), 32'd0);

    // 17 random frames with no reads: overrun
    ovr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      if (rxm.size() < 16) rxm.push_back(b);
      else ovr = 1'b1;
      send(b, 1'b1, 8);
    end
    idle(4);
    st = 8'h04;
    st[4] = ovr;
    st[1] = (rxm.size() == 16);
    st[0] = (rxm.size() > 0);
    rchk("rx_overrun_status", 3'd1, st);
    wr(3'd2, 8'h01);
    st[4] = 1'b0;
    rchk("rx_ovr_cleared", 3'd1, st);
    while (rxm.size() > 0) begin
      b = rxm.pop_front();
      rchk("rx_fifo_data", 3'd0, b);
    end
    rchk("rx_drained", 3'd1, 8'h04);

    // framing error: no push, sticky flag
    send(8'($urandom), 1'b0, 8);
    idle(4);
    rchk("frame_err", 3'd1, 8'h24);
    chk("ferr_no_irq", 32'(rx_irq), 32'd0);
    wr(3'd2, 8'h01);
    rchk("ferr_cleared", 3'd1, 8'h04);

    // one-clock glitch on idle line
    @(negedge clk);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    idle(20);
    rchk("glitch_ignored", 3'd1, 8'h04);
    b = 8'($urandom);
    send(b, 1'b1, 8);
    idle(4);
    rchk("rx_after_glitch", 3'd0, b);

    // flush both FIFOs
    send(8'($urandom), 1'b1, 8);
    send(8'($urandom), 1'b1, 8);
    idle(4);
    rchk("pre_flush", 3'd1, 8'h05);
    wr(3'd2, 8'h02);
    rchk("post_flush", 3'd1, 8'h04);
    chk("flush_irq", 32'(rx_irq), 32'd0);

    // flush during an incoming frame keeps that frame
    b = 8'($urandom);
    fork
      send(b, 1'b1, 8);
      begin
        idle(20);
        wr(3'd2, 8'h02);
      end
    join
    idle(4);
    rchk("rx_after_flush", 3'd0, b);

`ifdef UART_LOOPBACK_EN
    wr(3'd2, 8'h04);
    rchk("ctrl_lb", 3'd2, 8'h04);
    rxd = 1'b0;
    b = 8'h5A;
    wr(3'd0, b);
    idle(110);
    rchk("lb_status", 3'd1, 8'h05);
    rchk("lb_data", 3'd0, b);
    rxd = 1'b1;
    wr(3'd2, 8'h00);
`else
    wr(3'd2, 8'h04);
    rchk("ctrl_no_lb", 3'd2, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
